clock_controller: RTL and testbench
===================================

# clock_controller

Timekeeping controller for the wall clock. It consumes the one-cycle, 1 Hz enable pulse and sequences a BCD hours/minutes/seconds register set. A three-state mode machine lets the user set hours and minutes from two debounced push-button pulses, and it drives a blink flag for the display driver. It sits between the 1 Hz enable generator and the seven-segment display multiplexer.

## Interface
- BLINK_EN, 1, when 1 the field being set blinks; when 0, ctrl_blank is held 0.
- ctrl_clock  in  1  system clock (50 MHz); every register updates on its rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- ctrl_tick  in  1  1 Hz enable pulse, one ctrl_clock cycle wide.
- ctrl_mode  in  1  debounced mode button, one-cycle pulse.
- ctrl_inc  in  1  debounced increment button, one-cycle pulse.
- ctrl_hour  out  8  BCD hours, {tens[7:4], units[3:0]}, 00–23.
- ctrl_min  out  8  BCD minutes, 00–59.
- ctrl_sec  out  8  BCD seconds, 00–59.
- ctrl_state  out  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
- ctrl_blank  out  1  1 means the display blanks the selected field during this half-period.

## Operation
- States and transitions on ctrl_mode: RUN → SET_HOUR → SET_MIN → RUN. No other transitions. State encoding 3 is unreachable; if it is ever reached, the next edge goes to RUN.
- RUN behaviour:
  - ctrl_tick increments seconds.
  - Seconds 59→00 carries into minutes. Minutes 59→00 carries into hours. Hours 23→00 with no carry out.
  - Full rollover: 23:59:59 → 00:00:00 on a single tick.
  - ctrl_inc is ignored.
- SET_HOUR behaviour:
  - ctrl_inc increments hours modulo 24 (23→00). Minutes are unaffected.
  - ctrl_tick does not advance time; it only toggles the blink phase.
- SET_MIN behaviour:
  - ctrl_inc increments minutes modulo 60 (59→00). Nothing carries into hours.
  - ctrl_tick toggles the blink phase only.
- On the SET_MIN→RUN transition, seconds are cleared to 00 on the same edge.
- Entering any SET state sets the blink phase to "visible" (ctrl_blank=0).
- ctrl_blank equals the blink phase in SET states and is 0 in RUN.
- Priority when pulses coincide in the same cycle:
  - ctrl_mode beats ctrl_inc: the state advances and the increment is dropped.
  - In RUN, ctrl_mode and ctrl_tick together: the tick is applied and the state moves to SET_HOUR.
  - In SET states, ctrl_inc and ctrl_tick together: the increment is applied and the blink phase toggles.
- BCD rule: each digit is held in a 4-bit counter. Units wrap 9→0 with carry to tens. Modulus is checked on the full two-digit value (23, 59), never on binary arithmetic. Digits above 9 can never appear.

## Timing
- Reset (asynchronous, ctrl_reset=0):
  - ctrl_hour=8'h00, ctrl_min=8'h00, ctrl_sec=8'h00.
  - ctrl_state=RUN, ctrl_blank=0, blink phase visible.
- Release from reset is synchronous to ctrl_clock. The first tick is honoured on the first edge where ctrl_reset=1.
- All outputs are registered. Latency from an input pulse to the output change is 1 ctrl_clock cycle. There is no combinational path from inputs to outputs.
- Inputs are sampled on every edge. Held-high inputs are not pulse-detected here: each high cycle counts as one event. Upstream logic guarantees single-cycle pulses.
- Reset asserted mid-operation (in a SET state, or on a carry cycle) forces reset values immediately. No partial update survives.

## Structure
- Package clock_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {RUN, SET_HOUR, SET_MIN}.
  - Constants HOUR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59.
- Sub-module bcd_mod_counter, instantiated three times:
  - Ports: clock, reset, clear, inc, max (8-bit BCD), value, carry.
  - carry is combinational and high when inc is asserted and value==max.
- The FSM, blink phase and input priority logic live in clock_controller.

## Test plan
- Reset, then 61 ticks in RUN → ctrl_sec=8'h01, ctrl_min=8'h01, ctrl_hour=8'h00.
- Preload 23:59:58 through the set path, then 2 ticks → 23:59:59, then 00:00:00 with no stray carry.
- mode, then 25 inc → SET_HOUR with ctrl_hour=8'h01. mode, then 61 inc → SET_MIN with ctrl_min=8'h01 and ctrl_hour still 8'h01. mode → RUN with ctrl_sec=8'h00.
- In SET_HOUR, ctrl_mode and ctrl_inc in the same cycle → state SET_MIN and hours unchanged. In RUN, ctrl_mode and ctrl_tick together → seconds +1 and state SET_HOUR.
- In SET_MIN, 3 ticks → ctrl_blank sequence 0→1→0→1 and time frozen. With BLINK_EN=0 → ctrl_blank stays 0.
- Assert ctrl_reset asynchronously (off a clock edge) while in SET_MIN at 12:34 → outputs go to 00:00:00, RUN, ctrl_blank=0 before the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the wall-clock timekeeping controller.
//   ctrl_state_t : mode machine states (RUN, SET_HOUR, SET_MIN)
//   HOUR_MAX     : last hour value before wrap (BCD 23)
//   MIN_MAX      : last minute value before wrap (BCD 59)
//   SEC_MAX      : last second value before wrap (BCD 59)
// ---------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } ctrl_state_t;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] SEC_MAX  = 8'h59;

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that wraps to 00 after reaching a programmable
// two-digit BCD maximum.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears value to 00
//   clear : synchronous clear to 00 (wins over inc)
//   inc   : advance by one on this edge
//   max   : BCD value after which the counter wraps to 00
//   value : registered BCD count {tens, units}
//   carry : combinational, high when inc is asserted and value == max
// ---------------------------------------------------------------------------
module bcd_mod_counter
   import clock_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   input  logic [7:0] max,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   // The wrap test compares the whole two-digit BCD value, so the units digit
   // only ever steps 0..9 and tens only advances on a units 9->0 step.
   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = 8'h00;
      end else if (inc) begin
         if (value_q == max) begin
            value_d = 8'h00;
         end else if (value_q[3:0] == 4'd9) begin
            value_d = {value_q[7:4] + 4'd1, 4'd0};
         end else begin
            value_d = {value_q[7:4], value_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_q <= 8'h00;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc && (value_q == max);

endmodule

// File: rtl/clock_controller.sv
// ---------------------------------------------------------------------------
// clock_controller
// BCD hours/minutes/seconds timekeeper with a RUN / SET_HOUR / SET_MIN mode
// machine and a blink flag for the display multiplexer.
//   BLINK_EN   : 1 lets the field being set blink; 0 holds ctrl_blank at 0
//   ctrl_clock : system clock
//   ctrl_reset : asynchronous active-low reset
//   ctrl_tick  : 1 Hz enable pulse
//   ctrl_mode  : mode button pulse (RUN -> SET_HOUR -> SET_MIN -> RUN)
//   ctrl_inc   : increment button pulse (active in SET states only)
//   ctrl_hour  : BCD hours 00-23
//   ctrl_min   : BCD minutes 00-59
//   ctrl_sec   : BCD seconds 00-59
//   ctrl_state : current mode (0 RUN, 1 SET_HOUR, 2 SET_MIN)
//   ctrl_blank : 1 = blank the selected field this half-period
// ---------------------------------------------------------------------------
module clock_controller
   import clock_pkg::*;
#(
   parameter bit BLINK_EN = 1'b1
) (
   input  logic       ctrl_clock,
   input  logic       ctrl_reset,
   input  logic       ctrl_tick,
   input  logic       ctrl_mode,
   input  logic       ctrl_inc,
   output logic [7:0] ctrl_hour,
   output logic [7:0] ctrl_min,
   output logic [7:0] ctrl_sec,
   output logic [1:0] ctrl_state,
   output logic       ctrl_blank
);

   ctrl_state_t state_q, state_d;
   logic        blink_q, blink_d;
   logic        blank_q;

   logic sec_inc, min_inc, hour_inc, sec_clr;
   logic sec_carry, min_carry, hour_carry;
   logic in_run, in_set_hour, in_set_min;

   assign in_run      = (state_q == RUN);
   assign in_set_hour = (state_q == SET_HOUR);
   assign in_set_min  = (state_q == SET_MIN);

   // In RUN the tick is honoured even when mode arrives in the same cycle.
   // In SET states mode wins over inc, and nothing carries between fields.
   assign sec_inc  = in_run && ctrl_tick;
   assign min_inc  = in_run ? sec_carry : (in_set_min && ctrl_inc && !ctrl_mode);
   assign hour_inc = in_run ? min_carry : (in_set_hour && ctrl_inc && !ctrl_mode);
   assign sec_clr  = in_set_min && ctrl_mode;

   bcd_mod_counter u_sec (
      .clock (ctrl_clock),
      .reset (ctrl_reset),
      .clear (sec_clr),
      .inc   (sec_inc),
      .max   (SEC_MAX),
      .value (ctrl_sec),
      .carry (sec_carry)
   );

   bcd_mod_counter u_min (
      .clock (ctrl_clock),
      .reset (ctrl_reset),
      .clear (1'b0),
      .inc   (min_inc),
      .max   (MIN_MAX),
      .value (ctrl_min),
      .carry (min_carry)
   );

   // Hours wrap 23 -> 00 silently; the carry out is intentionally unused.
   bcd_mod_counter u_hour (
      .clock (ctrl_clock),
      .reset (ctrl_reset),
      .clear (1'b0),
      .inc   (hour_inc),
      .max   (HOUR_MAX),
      .value (ctrl_hour),
      .carry (hour_carry)
   );

   always_comb begin
      state_d = state_q;
      blink_d = blink_q;
      case (state_q)
         RUN: begin
            blink_d = 1'b0;
            if (ctrl_mode) state_d = SET_HOUR;
         end
         SET_HOUR: begin
            if (ctrl_mode)      state_d = SET_MIN;
            else if (ctrl_tick) blink_d = !blink_q;
         end
         SET_MIN: begin
            if (ctrl_mode)      state_d = RUN;
            else if (ctrl_tick) blink_d = !blink_q;
         end
         default: begin
            state_d = RUN;
            blink_d = 1'b0;
         end
      endcase
      // Any mode change starts the new field in the visible phase.
      if (state_d != state_q) blink_d = 1'b0;
   end

   always_ff @(posedge ctrl_clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         state_q <= RUN;
         blink_q <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
         // Registered copy of the display flag so the output has no
         // combinational path from the state decode.
         blank_q <= BLINK_EN && (state_d != RUN) && blink_d;
      end
   end

   assign ctrl_state = state_q;
   assign ctrl_blank = blank_q;

   logic unused_hour_carry;
   assign unused_hour_carry = hour_carry;

endmodule

// File: tb/tb_clock_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_controller
// Self-checking bench for clock_controller: a table of single-cycle vectors
// with fixed expected outputs, hand-written multi-cycle sequences, and a
// randomized run compared against a seconds-of-day reference model.
// A second instance with BLINK_EN=0 shares the stimulus; its blank output
// must stay 0.
// ---------------------------------------------------------------------------
module tb_clock_controller;

   logic       clk;
   logic       rst_n;
   logic       tick, mode, inc;
   logic [7:0] hour, min, sec;
   logic [1:0] state;
   logic       blank;
   logic [7:0] hour2, min2, sec2;
   logic [1:0] state2;
   logic       blank2;

   int checks = 0;
   int errors = 0;

   // Reference model: time as plain integers, mode as 0/1/2, blink phase.
   int m_h, m_m, m_s, m_st;
   bit m_bl;

   clock_controller #(.BLINK_EN(1'b1)) dut (
      .ctrl_clock (clk),
      .ctrl_reset (rst_n),
      .ctrl_tick  (tick),
      .ctrl_mode  (mode),
      .ctrl_inc   (inc),
      .ctrl_hour  (hour),
      .ctrl_min   (min),
      .ctrl_sec   (sec),
      .ctrl_state (state),
      .ctrl_blank (blank)
   );

   clock_controller #(.BLINK_EN(1'b0)) dut_noblink (
      .ctrl_clock (clk),
      .ctrl_reset (rst_n),
      .ctrl_tick  (tick),
      .ctrl_mode  (mode),
      .ctrl_inc   (inc),
      .ctrl_hour  (hour2),
      .ctrl_min   (min2),
      .ctrl_sec   (sec2),
      .ctrl_state (state2),
      .ctrl_blank (blank2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_bl = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit m, input bit i);
      int total;
      case (m_st)
         0: begin
            if (t) begin
               total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
               m_h = total / 3600;
               m_m = (total / 60) % 60;
               m_s = total % 60;
            end
            if (m) begin m_st = 1; m_bl = 1'b0; end
         end
         1: begin
            if (m) begin m_st = 2; m_bl = 1'b0; end
            else begin
               if (i) m_h = (m_h + 1) % 24;
               if (t) m_bl = !m_bl;
            end
         end
         default: begin
            if (m) begin m_st = 0; m_s = 0; m_bl = 1'b0; end
            else begin
               if (i) m_m = (m_m + 1) % 60;
               if (t) m_bl = !m_bl;
            end
         end
      endcase
   endtask

   task automatic check(input string name, input logic [7:0] eh, input logic [7:0] em,
                        input logic [7:0] es, input logic [1:0] est, input logic eb);
      checks++;
      if ({hour, min, sec, state, blank} !== {eh, em, es, est, eb}) begin
         errors++;
         $display("FAIL %s: got %h:%h:%h state=%0d blank=%b, want %h:%h:%h state=%0d blank=%b",
                  name, hour, min, sec, state, blank, eh, em, es, est, eb);
      end
      checks++;
      if ({hour2, min2, sec2, state2, blank2} !== {eh, em, es, est, 1'b0}) begin
         errors++;
         $display("FAIL %s_noblink: got %h:%h:%h state=%0d blank=%b, want %h:%h:%h state=%0d blank=0",
                  name, hour2, min2, sec2, state2, blank2, eh, em, es, est);
      end
   endtask

   task automatic check_model(input string name);
      check(name, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_st),
            (m_st != 0) && m_bl);
   endtask

   // Called at a falling edge: drive, let the rising edge sample, settle at
   // the next falling edge with inputs returned low.
   task automatic do_cycle(input bit t, input bit m, input bit i);
      tick = t; mode = m; inc = i;
      @(posedge clk);
      model_step(t, m, i);
      @(negedge clk);
      tick = 1'b0; mode = 1'b0; inc = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
      rst_n = 1'b1;
      $display("reset applied and released");
   endtask

   typedef struct {
      bit         t, m, i;
      logic [7:0] h, mi, s;
      logic [1:0] st;
      bit         bl;
   } vec_t;

   vec_t vecs[12];

   initial begin
      rst_n = 1'b0; tick = 1'b0; mode = 1'b0; inc = 1'b0;
      model_reset();

      // {tick, mode, inc} -> expected {hour, min, sec, state, blank}
      vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 8'h01, 2'd0, 0};
      vecs[1]  = '{1, 0, 0, 8'h00, 8'h00, 8'h02, 2'd0, 0};
      vecs[2]  = '{1, 1, 0, 8'h00, 8'h00, 8'h03, 2'd1, 0}; // tick kept, enter SET_HOUR
      vecs[3]  = '{0, 0, 1, 8'h01, 8'h00, 8'h03, 2'd1, 0};
      vecs[4]  = '{1, 0, 0, 8'h01, 8'h00, 8'h03, 2'd1, 1};
      vecs[5]  = '{1, 0, 1, 8'h02, 8'h00, 8'h03, 2'd1, 0}; // inc and blink toggle
      vecs[6]  = '{0, 1, 1, 8'h02, 8'h00, 8'h03, 2'd2, 0}; // mode drops inc
      vecs[7]  = '{0, 0, 1, 8'h02, 8'h01, 8'h03, 2'd2, 0};
      vecs[8]  = '{1, 0, 0, 8'h02, 8'h01, 8'h03, 2'd2, 1};
      vecs[9]  = '{0, 1, 0, 8'h02, 8'h01, 8'h00, 2'd0, 0}; // seconds cleared
      vecs[10] = '{1, 0, 0, 8'h02, 8'h01, 8'h01, 2'd0, 0};
      vecs[11] = '{0, 0, 1, 8'h02, 8'h01, 8'h01, 2'd0, 0}; // inc ignored in RUN

      apply_reset();
      for (int k = 0; k < 12; k++) begin
         do_cycle(vecs[k].t, vecs[k].m, vecs[k].i);
         $display("vec %0d: t=%0d m=%0d i=%0d -> %h:%h:%h st=%0d bl=%b",
                  k, vecs[k].t, vecs[k].m, vecs[k].i, hour, min, sec, state, blank);
         check($sformatf("vec%0d", k), vecs[k].h, vecs[k].mi, vecs[k].s, vecs[k].st, vecs[k].bl);
      end

      // 61 ticks from reset
      apply_reset();
      repeat (61) do_cycle(1, 0, 0);
      $display("seq 61 ticks -> %h:%h:%h", hour, min, sec);
      check("ticks61", 8'h00, 8'h01, 8'h01, 2'd0, 1'b0);

      // Set path wrap-around: 25 hour incs, 61 minute incs
      apply_reset();
      do_cycle(0, 1, 0);
      repeat (25) do_cycle(0, 0, 1);
      $display("seq 25 hour incs -> %h st=%0d", hour, state);
      check("hour25", 8'h01, 8'h00, 8'h00, 2'd1, 1'b0);
      do_cycle(0, 1, 0);
      repeat (61) do_cycle(0, 0, 1);
      $display("seq 61 min incs -> %h:%h st=%0d", hour, min, state);
      check("min61", 8'h01, 8'h01, 8'h00, 2'd2, 1'b0);
      do_cycle(1, 0, 0);
      do_cycle(0, 1, 0);
      $display("seq exit set -> %h:%h:%h st=%0d", hour, min, sec, state);
      check("exit_set", 8'h01, 8'h01, 8'h00, 2'd0, 1'b0);

      // Full-day rollover via preload 23:59:00 then ticks
      apply_reset();
      do_cycle(0, 1, 0);
      repeat (23) do_cycle(0, 0, 1);
      do_cycle(0, 1, 0);
      repeat (59) do_cycle(0, 0, 1);
      do_cycle(0, 1, 0);
      repeat (58) do_cycle(1, 0, 0);
      check("pre_2359_58", 8'h23, 8'h59, 8'h58, 2'd0, 1'b0);
      do_cycle(1, 0, 0);
      $display("seq rollover step1 -> %h:%h:%h", hour, min, sec);
      check("rollover_59", 8'h23, 8'h59, 8'h59, 2'd0, 1'b0);
      do_cycle(1, 0, 0);
      $display("seq rollover step2 -> %h:%h:%h", hour, min, sec);
      check("rollover_00", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);

      // Blink sequence in SET_MIN with frozen time
      do_cycle(0, 1, 0);
      do_cycle(0, 1, 0);
      check("blink0", 8'h00, 8'h00, 8'h00, 2'd2, 1'b0);
      do_cycle(1, 0, 0);
      $display("seq blink tick1 -> bl=%b", blank);
      check("blink1", 8'h00, 8'h00, 8'h00, 2'd2, 1'b1);
      do_cycle(1, 0, 0);
      $display("seq blink tick2 -> bl=%b", blank);
      check("blink2", 8'h00, 8'h00, 8'h00, 2'd2, 1'b0);
      do_cycle(1, 0, 0);
      $display("seq blink tick3 -> bl=%b", blank);
      check("blink3", 8'h00, 8'h00, 8'h00, 2'd2, 1'b1);

      // Asynchronous reset in SET_MIN at 12:34
      apply_reset();
      do_cycle(0, 1, 0);
      repeat (12) do_cycle(0, 0, 1);
      do_cycle(0, 1, 0);
      repeat (34) do_cycle(0, 0, 1);
      check("pre_async", 8'h12, 8'h34, 8'h00, 2'd2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      $display("seq async reset -> %h:%h:%h st=%0d bl=%b", hour, min, sec, state, blank);
      check("async_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized run against the reference model
      for (int k = 0; k < 1000; k++) begin
         bit rt, rm, ri;
         rt = ($urandom_range(3) == 0);
         rm = ($urandom_range(15) == 0);
         ri = ($urandom_range(2) == 0);
         do_cycle(rt, rm, ri);
         $display("rand %0d: t=%0d m=%0d i=%0d -> %h:%h:%h st=%0d bl=%b",
                  k, rt, rm, ri, hour, min, sec, state, blank);
         check($sformatf("rand%0d", k), to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_st),
               (m_st != 0) && m_bl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
